// File: rtl/m_axil_cmd.sv
// AXI4-Lite master. Each accepted command becomes one AXI-Lite write or read.
// The result is held on the response port until it is consumed; only one transaction is outstanding.
module m_axil_cmd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    axi_clock,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_we,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WRESP = 3'd2,
    RD_A  = 3'd3,
    RD_D  = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_WIDTH/8-1:0] wstrb_r;
  logic                    awvalid_r;
  logic                    wvalid_r;
  logic                    bready_r;
  logic                    arvalid_r;
  logic                    rready_r;
  logic                    rsp_valid_r;
  logic                    rsp_we_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic [1:0]              rsp_resp_r;
  logic                    aw_done_s;
  logic                    w_done_s;

  assign cmd_ready      = (state_r == IDLE);
  assign m_axil_awaddr  = addr_r;
  assign m_axil_araddr  = addr_r;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_wdata   = wdata_r;
  assign m_axil_wstrb   = wstrb_r;
  assign m_axil_awvalid = awvalid_r;
  assign m_axil_wvalid  = wvalid_r;
  assign m_axil_bready  = bready_r;
  assign m_axil_arvalid = arvalid_r;
  assign m_axil_rready  = rready_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_we         = rsp_we_r;
  assign rsp_rdata      = rsp_rdata_r;
  assign rsp_resp       = rsp_resp_r;

  // Write-channel completion: a channel is done once its valid has dropped or it handshakes now.
  always_comb begin
    aw_done_s = !awvalid_r || m_axil_awready;
    w_done_s  = !wvalid_r  || m_axil_wready;
  end

  // Transaction FSM with all AXI and response outputs registered.
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
      wstrb_r     <= {(DATA_WIDTH/8){1'b0}};
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_resp_r  <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            addr_r  <= cmd_addr;
            wdata_r <= cmd_wdata;
            wstrb_r <= cmd_wstrb;
            if (cmd_we) begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= WR;
            end else begin
              arvalid_r <= 1'b1;
              state_r   <= RD_A;
            end
          end
        end
        WR: begin
          // AW and W retire independently; B is only accepted once both are gone.
          if (awvalid_r && m_axil_awready) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && m_axil_wready) begin
            wvalid_r <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            bready_r <= 1'b1;
            state_r  <= WRESP;
          end
        end
        WRESP: begin
          if (m_axil_bvalid && bready_r) begin
            rsp_resp_r  <= m_axil_bresp;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_we_r    <= 1'b1;
            rsp_valid_r <= 1'b1;
            bready_r    <= 1'b0;
            state_r     <= RSP;
          end
        end
        RD_A: begin
          if (arvalid_r && m_axil_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RD_D;
          end
        end
        RD_D: begin
          if (m_axil_rvalid && rready_r) begin
            rsp_rdata_r <= m_axil_rdata;
            rsp_resp_r  <= m_axil_rresp;
            rsp_we_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rready_r    <= 1'b0;
            state_r     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_axil_cmd.sv
// Bench for m_axil_cmd: an AXI-Lite register slave with programmable stalls, directed cases,
// and randomized commands checked against a word-array reference model.
module tb_m_axil_cmd;

  logic        axi_clock = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [4:0]  cmd_addr = 5'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic [3:0]  cmd_wstrb = 4'd0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [4:0]  m_axil_awaddr, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [31:0] m_axil_wdata, m_axil_rdata;
  logic [3:0]  m_axil_wstrb;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;

  int errors = 0;
  int checks = 0;

  // slave configuration and state
  int          aw_delay = 0, w_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] smem [8];
  int          aw_wait, w_wait, r_wait;
  logic        aw_got, w_got, r_pend;
  logic [4:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, b_hs_n = 0, r_hs_n = 0;
  logic [4:0]  cur_awaddr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wstrb;

  // protocol monitor state
  logic        aw_seen, w_seen, ar_seen, p_aw_pend, p_w_pend, p_ar_pend;
  logic [4:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;
  int          bviol = 0, rviol = 0, sviol = 0;

  logic [31:0] ref_mem [8];

  m_axil_cmd #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .axi_clock(axi_clock), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr),
    .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready)
  );

  always #5 axi_clock = ~axi_clock;

  assign m_axil_awready = (aw_wait >= aw_delay);
  assign m_axil_wready  = (w_wait >= w_delay);
  assign m_axil_arready = 1'b1;
  assign cur_awaddr = aw_got ? s_awaddr : m_axil_awaddr;
  assign cur_wdata  = w_got ? s_wdata : m_axil_wdata;
  assign cur_wstrb  = w_got ? s_wstrb : m_axil_wstrb;

  function automatic logic [31:0] slave_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_write(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  // AXI-Lite register slave with configurable ready/valid stalls
  always @(posedge axi_clock) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      aw_wait <= 0; w_wait <= 0; r_wait <= 0;
      m_axil_bvalid <= 1'b0; m_axil_rvalid <= 1'b0;
      m_axil_bresp <= 2'b00; m_axil_rresp <= 2'b00; m_axil_rdata <= 32'd0;
      s_awaddr <= 5'd0; s_araddr <= 5'd0; s_wdata <= 32'd0; s_wstrb <= 4'd0;
      for (int i = 0; i < 8; i++) smem[i] <= 32'd0;
    end else begin
      if (m_axil_awvalid && m_axil_awready) begin
        aw_got <= 1'b1; s_awaddr <= m_axil_awaddr; aw_wait <= 0; aw_hs_n <= aw_hs_n + 1;
      end else if (m_axil_awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (m_axil_wvalid && m_axil_wready) begin
        w_got <= 1'b1; s_wdata <= m_axil_wdata; s_wstrb <= m_axil_wstrb; w_wait <= 0;
        w_hs_n <= w_hs_n + 1;
      end else if (m_axil_wvalid) begin
        w_wait <= w_wait + 1;
      end
      if ((aw_got || (m_axil_awvalid && m_axil_awready)) &&
          (w_got || (m_axil_wvalid && m_axil_wready)) && !m_axil_bvalid) begin
        smem[cur_awaddr[4:2]] <= slave_merge(smem[cur_awaddr[4:2]], cur_wdata, cur_wstrb);
        m_axil_bvalid <= 1'b1; m_axil_bresp <= bresp_cfg;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (m_axil_bvalid && m_axil_bready) begin
        m_axil_bvalid <= 1'b0; b_hs_n <= b_hs_n + 1;
      end
      if (m_axil_arvalid && m_axil_arready) begin
        ar_hs_n <= ar_hs_n + 1; s_araddr <= m_axil_araddr;
        if (r_delay == 0) begin
          m_axil_rvalid <= 1'b1; m_axil_rdata <= smem[m_axil_araddr[4:2]]; m_axil_rresp <= rresp_cfg;
        end else begin
          r_pend <= 1'b1; r_wait <= 1;
        end
      end else if (r_pend) begin
        if (r_wait >= r_delay) begin
          m_axil_rvalid <= 1'b1; m_axil_rdata <= smem[s_araddr[4:2]]; m_axil_rresp <= rresp_cfg;
          r_pend <= 1'b0;
        end else begin
          r_wait <= r_wait + 1;
        end
      end
      if (m_axil_rvalid && m_axil_rready) begin
        m_axil_rvalid <= 1'b0; r_hs_n <= r_hs_n + 1;
      end
    end
  end

  // Protocol monitor: early bready/rready and payload stability while valid is stalled
  always @(posedge axi_clock) begin
    if (rst) begin
      aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0;
      p_aw_pend <= 1'b0; p_w_pend <= 1'b0; p_ar_pend <= 1'b0;
      p_awaddr <= 5'd0; p_araddr <= 5'd0; p_wdata <= 32'd0;
    end else begin
      if (m_axil_bready && !(aw_seen && w_seen)) bviol <= bviol + 1;
      if (m_axil_rready && !ar_seen) rviol <= rviol + 1;
      if (p_aw_pend && (!m_axil_awvalid || m_axil_awaddr != p_awaddr)) sviol <= sviol + 1;
      if (p_w_pend && (!m_axil_wvalid || m_axil_wdata != p_wdata)) sviol <= sviol + 1;
      if (p_ar_pend && (!m_axil_arvalid || m_axil_araddr != p_araddr)) sviol <= sviol + 1;
      if (m_axil_awvalid && m_axil_awready) aw_seen <= 1'b1;
      if (m_axil_wvalid && m_axil_wready) w_seen <= 1'b1;
      if (m_axil_arvalid && m_axil_arready) ar_seen <= 1'b1;
      if (m_axil_bvalid && m_axil_bready) begin aw_seen <= 1'b0; w_seen <= 1'b0; end
      if (m_axil_rvalid && m_axil_rready) ar_seen <= 1'b0;
      p_aw_pend <= m_axil_awvalid && !m_axil_awready; p_awaddr <= m_axil_awaddr;
      p_w_pend  <= m_axil_wvalid && !m_axil_wready;   p_wdata  <= m_axil_wdata;
      p_ar_pend <= m_axil_arvalid && !m_axil_arready; p_araddr <= m_axil_araddr;
    end
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_clock);
    #1;
  endtask

  // Handshake one command; returns one step after the accepting edge (cycle 1).
  task automatic issue(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin step(); n++; end
    check1("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    step();
    cmd_valid = 1'b0;
  endtask

  // Wait for the response, hold it off for 'hold' cycles, then consume it.
  task automatic finish(input int hold, output logic g_we, output logic [31:0] g_rd,
                        output logic [1:0] g_rs);
    int n, hs0;
    n = 0;
    while (!rsp_valid && n < 200) begin step(); n++; end
    check1("rsp_wait", rsp_valid, 1'b1);
    g_we = rsp_we; g_rd = rsp_rdata; g_rs = rsp_resp;
    hs0 = aw_hs_n + w_hs_n + ar_hs_n;
    for (int i = 0; i < hold; i++) begin
      step();
      check1("hold_valid", rsp_valid, 1'b1);
      check1("hold_we", rsp_we, g_we);
      check32("hold_rdata", rsp_rdata, g_rd);
      check32("hold_resp", 32'(rsp_resp), 32'(g_rs));
      check1("hold_cmd_ready", cmd_ready, 1'b0);
      check32("hold_axi_quiet", 32'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                                     m_axil_bready, m_axil_rready}), 32'd0);
      check32("hold_no_hs", 32'(aw_hs_n + w_hs_n + ar_hs_n), 32'(hs0));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check1("rsp_drop", rsp_valid, 1'b0);
    check1("cmd_ready_back", cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        g_we, we_t;
    logic [31:0] g_rd, d_t;
    logic [1:0]  g_rs;
    logic [4:0]  a_t;
    logic [3:0]  s_t;
    int          aw0, w0, ar0, hold, n;

    for (int i = 0; i < 8; i++) ref_mem[i] = 32'd0;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    check1("rst_cmd_ready", cmd_ready, 1'b1);
    check32("rst_valids", 32'({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                               m_axil_rready, rsp_valid}), 32'd0);
    check32("rst_rsp", 32'({rsp_we, rsp_resp}), 32'd0);
    check32("rst_rsp_rdata", rsp_rdata, 32'd0);
    check32("rst_addr", 32'({m_axil_awaddr, m_axil_araddr}), 32'd0);
    check32("rst_wdata", m_axil_wdata, 32'd0);
    check32("rst_prot", 32'({m_axil_awprot, m_axil_arprot}), 32'd0);

    // write with slave always ready: exact cycle latency
    aw0 = aw_hs_n; w0 = w_hs_n;
    issue(1'b1, 5'h0C, 32'hDEADBEEF, 4'hF);
    check1("w1_awvalid_c1", m_axil_awvalid, 1'b1);
    check1("w1_wvalid_c1", m_axil_wvalid, 1'b1);
    check32("w1_awaddr_c1", 32'(m_axil_awaddr), 32'h0C);
    check32("w1_wdata_c1", m_axil_wdata, 32'hDEADBEEF);
    check32("w1_wstrb_c1", 32'(m_axil_wstrb), 32'hF);
    check1("w1_bready_c1", m_axil_bready, 1'b0);
    step();
    check1("w1_bready_c2", m_axil_bready, 1'b1);
    check1("w1_bvalid_c2", m_axil_bvalid, 1'b1);
    check1("w1_rsp_valid_c2", rsp_valid, 1'b0);
    step();
    check1("w1_rsp_valid_c3", rsp_valid, 1'b1);
    finish(0, g_we, g_rd, g_rs);
    ref_mem[3] = ref_write(ref_mem[3], 32'hDEADBEEF, 4'hF);
    check1("w1_rsp_we", g_we, 1'b1);
    check32("w1_rsp_resp", 32'(g_rs), 32'd0);
    check32("w1_rsp_rdata", g_rd, 32'd0);
    check32("w1_slave_word3", smem[3], 32'hDEADBEEF);
    check32("w1_aw_hs", 32'(aw_hs_n - aw0), 32'd1);
    check32("w1_w_hs", 32'(w_hs_n - w0), 32'd1);

    // read back
    ar0 = ar_hs_n;
    issue(1'b0, 5'h0C, 32'd0, 4'h0);
    check1("r1_arvalid_c1", m_axil_arvalid, 1'b1);
    check32("r1_araddr_c1", 32'(m_axil_araddr), 32'h0C);
    check1("r1_rready_c1", m_axil_rready, 1'b0);
    step();
    check1("r1_rready_c2", m_axil_rready, 1'b1);
    check1("r1_arvalid_c2", m_axil_arvalid, 1'b0);
    step();
    check1("r1_rsp_valid_c3", rsp_valid, 1'b1);
    finish(0, g_we, g_rd, g_rs);
    check32("r1_rdata", g_rd, ref_mem[3]);
    check1("r1_rsp_we", g_we, 1'b0);
    check32("r1_rsp_resp", 32'(g_rs), 32'd0);
    check32("r1_ar_hs", 32'(ar_hs_n - ar0), 32'd1);

    // split write channels: AW late, then W late
    aw_delay = 3; w_delay = 0; aw0 = aw_hs_n; w0 = w_hs_n;
    issue(1'b1, 5'h04, 32'h12345678, 4'h3);
    step();
    check1("sp1_wvalid_dropped", m_axil_wvalid, 1'b0);
    check1("sp1_awvalid_held", m_axil_awvalid, 1'b1);
    check1("sp1_bready_low", m_axil_bready, 1'b0);
    finish(0, g_we, g_rd, g_rs);
    ref_mem[1] = ref_write(ref_mem[1], 32'h12345678, 4'h3);
    check32("sp1_aw_hs", 32'(aw_hs_n - aw0), 32'd1);
    check32("sp1_w_hs", 32'(w_hs_n - w0), 32'd1);
    check32("sp1_slave_word1", smem[1], ref_mem[1]);
    aw_delay = 0; w_delay = 3; aw0 = aw_hs_n; w0 = w_hs_n;
    issue(1'b1, 5'h08, 32'hA5A5_0F0F, 4'hF);
    step();
    check1("sp2_awvalid_dropped", m_axil_awvalid, 1'b0);
    check1("sp2_wvalid_held", m_axil_wvalid, 1'b1);
    check1("sp2_bready_low", m_axil_bready, 1'b0);
    finish(0, g_we, g_rd, g_rs);
    ref_mem[2] = ref_write(ref_mem[2], 32'hA5A5_0F0F, 4'hF);
    check32("sp2_aw_hs", 32'(aw_hs_n - aw0), 32'd1);
    check32("sp2_w_hs", 32'(w_hs_n - w0), 32'd1);
    check32("split_bready_early", 32'(bviol), 32'd0);
    w_delay = 0;

    // delayed rvalid, then response back-pressure
    r_delay = 5;
    issue(1'b0, 5'h04, 32'd0, 4'h0);
    step();
    n = 0;
    while (!m_axil_rvalid && n < 20) begin
      check1("bp_rready_held", m_axil_rready, 1'b1);
      step(); n++;
    end
    check1("bp_rvalid_seen", m_axil_rvalid, 1'b1);
    finish(4, g_we, g_rd, g_rs);
    check32("bp_rdata", g_rd, ref_mem[1]);
    check1("bp_rsp_we", g_we, 1'b0);
    r_delay = 0;

    // error response passes through, next command normal
    bresp_cfg = 2'b10;
    issue(1'b1, 5'h10, 32'h0BAD_F00D, 4'hF);
    finish(0, g_we, g_rd, g_rs);
    ref_mem[4] = ref_write(ref_mem[4], 32'h0BAD_F00D, 4'hF);
    check32("err_bresp", 32'(g_rs), 32'h2);
    check1("err_rsp_we", g_we, 1'b1);
    bresp_cfg = 2'b00;
    issue(1'b0, 5'h10, 32'd0, 4'h0);
    finish(0, g_we, g_rd, g_rs);
    check32("err_next_rdata", g_rd, ref_mem[4]);
    check32("err_next_resp", 32'(g_rs), 32'd0);

    // reset during WR with awready low
    aw_delay = 1000;
    issue(1'b1, 5'h14, 32'h7777_7777, 4'hF);
    step();
    check1("mid_in_wr", m_axil_awvalid, 1'b1);
    rst = 1'b1;
    step();
    check32("mid_rst_valids", 32'({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                                   m_axil_rready, rsp_valid}), 32'd0);
    check1("mid_rst_cmd_ready", cmd_ready, 1'b1);
    rst = 1'b0; aw_delay = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'd0;
    issue(1'b0, 5'h0C, 32'd0, 4'h0);
    finish(0, g_we, g_rd, g_rs);
    check32("mid_rst_readback", g_rd, 32'd0);

    // randomized commands against the reference model
    for (int k = 0; k < 40; k++) begin
      we_t = 1'($urandom_range(0, 1));
      a_t = 5'($urandom_range(0, 31));
      d_t = $urandom;
      s_t = 4'($urandom_range(0, 15));
      aw_delay = $urandom_range(0, 3);
      w_delay = $urandom_range(0, 3);
      r_delay = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3));
      rresp_cfg = 2'($urandom_range(0, 3));
      hold = $urandom_range(0, 2);
      aw0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n;
      issue(we_t, a_t, d_t, s_t);
      finish(hold, g_we, g_rd, g_rs);
      if (we_t) begin
        ref_mem[a_t[4:2]] = ref_write(ref_mem[a_t[4:2]], d_t, s_t);
        check1("rnd_wr_we", g_we, 1'b1);
        check32("rnd_wr_rdata", g_rd, 32'd0);
        check32("rnd_wr_resp", 32'(g_rs), 32'(bresp_cfg));
        check32("rnd_wr_hs", 32'({aw_hs_n - aw0, w_hs_n - w0, ar_hs_n - ar0}), 32'({32'd1, 32'd1, 32'd0}));
      end else begin
        check1("rnd_rd_we", g_we, 1'b0);
        check32("rnd_rd_rdata", g_rd, ref_mem[a_t[4:2]]);
        check32("rnd_rd_resp", 32'(g_rs), 32'(rresp_cfg));
        check32("rnd_rd_hs", 32'({aw_hs_n - aw0, w_hs_n - w0, ar_hs_n - ar0}), 32'({32'd0, 32'd0, 32'd1}));
      end
    end

    check32("mon_bready_early", 32'(bviol), 32'd0);
    check32("mon_rready_early", 32'(rviol), 32'd0);
    check32("mon_payload_stable", 32'(sviol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_axil_cmd.md
Name: m_axil_cmd

Overview:
- AXI4-Lite initiator (master) that turns a simple one-command-at-a-time request port into AXI-Lite write or read transactions.
- Drives the team's AXI-Lite register slaves from fabric logic (sequencers, test controllers) without a PS.
- Allows exactly one outstanding transaction.
- The result (read data plus response code) is returned on a held response port.

Parameters:
- DATA_WIDTH, 32, AXI data width; must be 32 (4 strobe bits).
- ADDR_WIDTH, 5, byte-address width of awaddr/araddr; word index is addr[ADDR_WIDTH-1:2].

Ports:
- axi_clock  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_we  out  1  echo of cmd_we
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  bresp/rresp captured from slave
- m_axil_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI4-Lite master directions and widths; awaddr/araddr ADDR_WIDTH, prot 3.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock axi_clock.
- Reset values:
  - state IDLE.
  - awvalid, wvalid, bready, arvalid, rready, rsp_valid all 0.
  - rsp_rdata 0, rsp_resp 0, rsp_we 0.
  - Address/data output registers 0.
  - awprot and arprot are tied to 3'b000.
- cmd_ready = (state==IDLE), combinational from state only; it is 1 in the first cycle after reset.
- FSM states: IDLE, WR, WRESP, RD_A, RD_D, RSP.
- IDLE, on cmd handshake:
  - Register addr, wdata, wstrb and we.
  - cmd_we=1: next state WR, with awvalid=1 and wvalid=1 from the next cycle.
  - cmd_we=0: next state RD_A, with arvalid=1 from the next cycle.
- WR:
  - awvalid and wvalid are cleared independently, the edge after their own handshake (valid&&ready).
  - AW and W may complete in either order or in the same cycle.
  - Payloads stay stable while valid is high.
  - When both are done, go to WRESP with bready=1.
- WRESP:
  - On bvalid&&bready: capture bresp into rsp_resp, set rsp_rdata=0, rsp_we=1, rsp_valid=1, bready=0, go to RSP.
- RD_A:
  - On arvalid&&arready: arvalid=0, rready=1, go to RD_D.
- RD_D:
  - On rvalid&&rready: capture rdata and rresp, rsp_we=0, rsp_valid=1, rready=0, go to RSP.
- RSP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid=0, go to IDLE. cmd_ready rises the following cycle.
- bready and rready are never asserted before the matching address phase has completed.
- Slave readies tied high give these latencies (cycle 0 = cmd handshake):
  - Write: AW/W handshake cycle 1, bready from cycle 2; slave bvalid in cycle 2 gives rsp_valid in cycle 3.
  - Read: AR handshake cycle 1, rready from cycle 2; rvalid in cycle 2 gives rsp_valid in cycle 3.
- Non-OKAY responses (SLVERR/DECERR) are passed through unmodified. No retry.
- No timeout: the FSM waits indefinitely for slave handshakes.
- Reset mid-transaction: all valids and readies drop at the next edge and state returns to IDLE. Any pending result is discarded. The attached slaves share rst.
- cmd_addr bits [1:0] are forwarded unchanged; the block does no alignment check.
- Total RTL 150-250 lines: one FSM, done flags for AW and W, output registers.

Test Plan:
- Write, slave always ready: cmd addr 5'h0C, wdata 32'hDEADBEEF, wstrb 4'hF.
  - Required: awaddr=0x0C and wdata on the bus cycle 1.
  - Required: bvalid cycle 2 gives rsp_valid cycle 3, rsp_we=1, rsp_resp=0.
  - Required: register slave word 3 = DEADBEEF.
- Read back: cmd read addr 5'h0C.
  - Required: rsp_rdata=32'hDEADBEEF, rsp_we=0, rsp_resp=0, and exactly one AR handshake.
- Split write channels: awready delayed 3 cycles, wready immediate, then the reverse.
  - Required: wvalid drops after its handshake while awvalid stays high.
  - Required: bready only after both handshakes; exactly one AW and one W handshake per command.
- Back-pressure:
  - Slave rvalid delayed 5 cycles: rready stays high the whole time.
  - rsp_ready held low 4 cycles: rsp_* stay stable, cmd_ready=0, no new AXI traffic.
- Error response: slave returns bresp=2'b10.
  - Required: rsp_resp=2'b10, FSM returns to IDLE, next command proceeds normally.
- Reset: assert rst while in WR with awready low.
  - Required: next edge all valids 0, cmd_ready=1.
  - Required: a following read returns the slave reset value 0.
